// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
interface if_stage_if;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        misalign;
  logic [31:0] stall_cnt;
  logic [31:0] squash_cnt;

  modport slave (
    input  en, redirect, redirect_pc, imem_rdata,
    output imem_addr, pc_id, pc4_id, instr_id, valid_id, misalign, stall_cnt, squash_cnt
  );

  modport master (
    output en, redirect, redirect_pc, imem_rdata,
    input  imem_addr, pc_id, pc4_id, instr_id, valid_id, misalign, stall_cnt, squash_cnt
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC, synchronous-read imem addressing, IF/ID register and debug counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.slave  bus
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic            boot_q;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] pc4_id_q, pc4_id_d;
  logic [XLEN-1:0] instr_id_q, instr_id_d;
  logic            valid_id_q, valid_id_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] squash_cnt_q, squash_cnt_d;

  // Next PC; reset pins the memory address to the boot vector while rst is held.
  always_comb begin
    pc_f_d = pc_f_q + XLEN'(4);
    if (rst) begin
      pc_f_d = RESET_PC;
    end else if (bus.redirect) begin
      pc_f_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (!boot_q) begin
      pc_f_d = RESET_PC;
    end else if (!bus.en) begin
      pc_f_d = pc_f_q;
    end
  end

  assign bus.imem_addr = pc_f_d;

  // IF/ID update and event counters.
  always_comb begin
    pc_id_d      = pc_id_q;
    pc4_id_d     = pc4_id_q;
    instr_id_d   = instr_id_q;
    valid_id_d   = valid_id_q;
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    misalign_d   = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

    if (bus.redirect) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      if (valid_id_q || boot_q) begin
        squash_cnt_d = squash_cnt_q + XLEN'(1);
      end
    end else if (!bus.en) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end else if (!boot_q) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end else begin
      instr_id_d = bus.imem_rdata;
      pc_id_d    = pc_f_q;
      pc4_id_d   = pc_f_q + XLEN'(4);
      valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q       <= RESET_PC;
      boot_q       <= 1'b0;
      pc_id_q      <= RESET_PC;
      pc4_id_q     <= RESET_PC + XLEN'(4);
      instr_id_q   <= NOP_INSTR;
      valid_id_q   <= 1'b0;
      misalign_q   <= 1'b0;
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      pc_f_q       <= pc_f_d;
      boot_q       <= 1'b1;
      pc_id_q      <= pc_id_d;
      pc4_id_q     <= pc4_id_d;
      instr_id_q   <= instr_id_d;
      valid_id_q   <= valid_id_d;
      misalign_q   <= misalign_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign bus.pc_id      = pc_id_q;
  assign bus.pc4_id     = pc4_id_q;
  assign bus.instr_id   = instr_id_q;
  assign bus.valid_id   = valid_id_q;
  assign bus.misalign   = misalign_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized checks of if_stage against a fetch-level reference model.
module tb_if_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SUB_I = 32'h4012_84B3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  if_stage_if bus0 ();
  if_stage_if bus1 ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: word i holds 0x1000_0000+i, with a sub placed at 0x8.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0008) return SUB_I;
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  always @(posedge clk) begin
    bus0.imem_rdata <= mem_word(bus0.imem_addr);
    bus1.imem_rdata <= mem_word(bus1.imem_addr);
  end

  // Reference: fetch address, started flag, what ID should hold, and event tallies.
  logic [31:0] m_fetch, m_pc_id, m_instr, m_stalls, m_squash;
  logic        m_started, m_valid, m_mis;

  task automatic model_reset();
    m_fetch = 32'h0; m_started = 1'b0; m_pc_id = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_stalls = 0; m_squash = 0;
  endtask

  function automatic logic [31:0] model_next(input logic e, input logic r, input logic [31:0] t);
    if (r) return t & 32'hFFFF_FFFC;
    if (!m_started) return 32'h0;
    if (!e) return m_fetch;
    return m_fetch + 32'd4;
  endfunction

  task automatic model_edge(input logic e, input logic r, input logic [31:0] t);
    logic [31:0] nxt;
    nxt = model_next(e, r, t);
    m_mis = r && (t[1:0] != 2'b00);
    if (r) begin
      if (m_valid || m_started) m_squash = m_squash + 1;
      m_instr = NOP; m_valid = 1'b0;
    end else if (!e) begin
      m_stalls = m_stalls + 1;
    end else if (!m_started) begin
      m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_fetch); m_pc_id = m_fetch; m_valid = 1'b1;
    end
    m_fetch = nxt;
    m_started = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_id"},      bus0.pc_id,      m_pc_id);
    chk({tag, ".pc4_id"},     bus0.pc4_id,     m_pc_id + 32'd4);
    chk({tag, ".instr_id"},   bus0.instr_id,   m_instr);
    chk({tag, ".valid_id"},   32'(bus0.valid_id), 32'(m_valid));
    chk({tag, ".misalign"},   32'(bus0.misalign), 32'(m_mis));
    chk({tag, ".stall_cnt"},  bus0.stall_cnt,  m_stalls);
    chk({tag, ".squash_cnt"}, bus0.squash_cnt, m_squash);
  endtask

  // One cycle: drive at negedge, check imem_addr, take the edge, check registered outputs.
  task automatic cycle(input logic e, input logic r, input logic [31:0] t, input string tag);
    bus0.en = e; bus0.redirect = r; bus0.redirect_pc = t;
    #1;
    chk({tag, ".imem_addr"}, bus0.imem_addr, model_next(e, r, t));
    @(posedge clk);
    model_edge(e, r, t);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    bus0.en = 1'b1; bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0;
    bus1.en = 1'b1; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.imem_addr", bus0.imem_addr, 32'h0);
    chk("reset1.pc_id", bus1.pc_id, 32'hFFFF_FFFC);
    rst = 1'b0;

    cycle(1'b1, 1'b0, 32'h0, "boot1");
    chk("boot1.bubble", 32'(bus0.valid_id), 32'd0);
    cycle(1'b1, 1'b0, 32'h0, "boot2");
    chk("boot2.instr", bus0.instr_id, 32'h1000_0000);
    chk("wrap.pc0", bus1.pc_id, 32'hFFFF_FFFC);
    chk("wrap.instr0", bus1.instr_id, 32'h4FFF_FFFF);
    cycle(1'b1, 1'b0, 32'h0, "run3");
    chk("run3.instr", bus0.instr_id, 32'h1000_0001);
    chk("wrap.pc1", bus1.pc_id, 32'h0000_0000);
    chk("wrap.instr1", bus1.instr_id, 32'h1000_0000);
    cycle(1'b1, 1'b0, 32'h0, "run4");
    chk("run4.sub", bus0.instr_id, SUB_I);

    cycle(1'b0, 1'b0, 32'h0, "stall");
    chk("stall.hold", bus0.instr_id, SUB_I);
    chk("stall.cnt", bus0.stall_cnt, 32'd1);
    cycle(1'b1, 1'b0, 32'h0, "resume");
    chk("resume.pc", bus0.pc_id, 32'h0000_000C);

    cycle(1'b1, 1'b1, 32'h0000_0100, "redir");
    chk("redir.instr", bus0.instr_id, NOP);
    chk("redir.squash", bus0.squash_cnt, 32'd1);
    cycle(1'b1, 1'b0, 32'h0, "target");
    chk("target.pc", bus0.pc_id, 32'h0000_0100);

    cycle(1'b0, 1'b1, 32'h0000_0200, "redir_stall");
    chk("redir_stall.cnt", bus0.stall_cnt, 32'd1);
    cycle(1'b1, 1'b0, 32'h0, "target2");
    chk("target2.pc", bus0.pc_id, 32'h0000_0200);

    cycle(1'b1, 1'b1, 32'h0000_0102, "misal");
    chk("misal.flag", 32'(bus0.misalign), 32'd1);
    cycle(1'b1, 1'b0, 32'h0, "misal_end");
    chk("misal_end.flag", 32'(bus0.misalign), 32'd0);
    chk("misal_end.pc", bus0.pc_id, 32'h0000_0100);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
            32'($urandom_range(0, 255)), "rand");
    end

    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst.imem_addr", bus0.imem_addr, 32'h0);
    chk("midrst.wrap_pc", bus1.pc_id, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, "reboot");
    chk("reboot.squash", bus0.squash_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
